// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle FSM state encodings and default timing constants.
// The paddle position block imports this package too.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } paddle_state_e;

  // 10 ms debounce and 400 px/s repeat at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int STEP_CYCLES_DEF     = 250_000;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// db changes only after DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK_100MHz,
  input  logic Reset_n,
  input  logic btn,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      db     <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      // Any sample that agrees with db restarts the stability window
      if (sync_2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_move_gen.sv
// Turns two raw paddle buttons into one-cycle moveUp/moveDown step pulses with auto-repeat.
// Handshake: moveUp/moveDown are single-cycle strobes, never both high, always separated by a low cycle.
module paddle_move_gen
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STEP_CYCLES     = STEP_CYCLES_DEF
) (
  input  logic       CLK_100MHz,
  input  logic       Reset_n,
  input  logic       BtnUp,
  input  logic       BtnDown,
  input  logic       Enable,
  output logic       moveUp,
  output logic       moveDown,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_db
);

  localparam int SW = cnt_width(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic          db_up;
  logic          db_dn;
  paddle_state_e state;
  paddle_state_e state_nxt;
  logic [SW-1:0] step_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_up (
    .CLK_100MHz (CLK_100MHz),
    .Reset_n    (Reset_n),
    .btn        (BtnUp),
    .db         (db_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_dn (
    .CLK_100MHz (CLK_100MHz),
    .Reset_n    (Reset_n),
    .btn        (BtnDown),
    .db         (db_dn)
  );

  // Direction changes always route through S_IDLE; both buttons held means no motion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Enable && db_up && !db_dn)      state_nxt = S_UP;
        else if (Enable && db_dn && !db_up) state_nxt = S_DOWN;
      end
      S_UP:    if (!Enable || !db_up || db_dn) state_nxt = S_IDLE;
      S_DOWN:  if (!Enable || !db_dn || db_up) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      moveUp   <= 1'b0;
      moveDown <= 1'b0;
    end else begin
      state <= state_nxt;
      // Pulse on the first held cycle and after each wrap, but never on the exit cycle
      moveUp   <= (state == S_UP)   && (state_nxt == S_UP)   && (step_cnt == '0);
      moveDown <= (state == S_DOWN) && (state_nxt == S_DOWN) && (step_cnt == '0);
      if (state_nxt == S_IDLE || state_nxt != state) begin
        step_cnt <= '0;
      end else if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

  assign dbg_state = state;
  assign dbg_db    = {db_dn, db_up};

endmodule

// File: tb/tb_paddle_move_gen.sv
// Directed bench for paddle_move_gen with a window-based behavioural model checked every cycle.
module tb_paddle_move_gen;

  localparam int D = 4;
  localparam int S = 8;
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic enable = 1'b1;
  logic move_up;
  logic move_dn;
  logic [1:0] dbg_state;
  logic [1:0] dbg_db;

  always #5 clk = ~clk;

  paddle_move_gen #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S)) dut (
    .CLK_100MHz (clk),
    .Reset_n    (rst_n),
    .BtnUp      (btn_up),
    .BtnDown    (btn_dn),
    .Enable     (enable),
    .moveUp     (move_up),
    .moveDown   (move_dn),
    .dbg_state  (dbg_state),
    .dbg_db     (dbg_db)
  );

  int cyc = 0;
  int vec = 0;
  int errs = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // A level flips once the last D synchronised samples (raw samples two edges old) all disagree with it.
  logic [D+1:0] h_up = '0;
  logic [D+1:0] h_dn = '0;
  logic m_db_up = 1'b0;
  logic m_db_dn = 1'b0;
  logic m_up = 1'b0;
  logic m_dn = 1'b0;
  int   m_state = M_IDLE;
  int   m_nxt = M_IDLE;
  int   m_edge = 0;
  int   m_entry = 0;
  logic m_cadence;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_up = '0;
      h_dn = '0;
      m_db_up = 1'b0;
      m_db_dn = 1'b0;
      m_up = 1'b0;
      m_dn = 1'b0;
      m_state = M_IDLE;
    end else begin
      m_edge++;
      m_nxt = m_state;
      if (m_state == M_IDLE) begin
        if (enable && m_db_up && !m_db_dn)      m_nxt = M_UP;
        else if (enable && m_db_dn && !m_db_up) m_nxt = M_DN;
      end else if (m_state == M_UP) begin
        if (!(enable && m_db_up && !m_db_dn)) m_nxt = M_IDLE;
      end else begin
        if (!(enable && m_db_dn && !m_db_up)) m_nxt = M_IDLE;
      end
      // Pulses land one edge after entry, then every S edges, while the direction is kept
      m_cadence = ((m_edge - m_entry - 1) % S) == 0;
      m_up = (m_state == M_UP) && (m_nxt == M_UP) && m_cadence;
      m_dn = (m_state == M_DN) && (m_nxt == M_DN) && m_cadence;
      if (m_nxt != m_state && m_nxt != M_IDLE) m_entry = m_edge;
      m_state = m_nxt;
      m_db_up = m_db_up ? (|h_up[D:1]) : (&h_up[D:1]);
      m_db_dn = m_db_dn ? (|h_dn[D:1]) : (&h_dn[D:1]);
      h_up = {h_up[D:0], btn_up};
      h_dn = {h_dn[D:0], btn_dn};
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int up_count, up_first, up_second, up_last;
  int dn_count, dn_first, dn_second, dn_last;
  logic db_up_rose;

  task automatic clear_mon();
    up_count = 0; up_first = -1; up_second = -1; up_last = -1;
    dn_count = 0; dn_first = -1; dn_second = -1; dn_last = -1;
    db_up_rose = 1'b0;
  endtask

  always @(negedge clk) begin
    check("moveUp", move_up, m_up);
    check("moveDown", move_dn, m_dn);
    check("state", dbg_state, m_state);
    check("db", dbg_db, {m_db_dn, m_db_up});
    check("exclusive", move_up & move_dn, 0);
    if (move_up) begin
      up_count++;
      if (up_first < 0) up_first = cyc;
      else if (up_second < 0) up_second = cyc;
      up_last = cyc;
    end
    if (move_dn) begin
      dn_count++;
      if (dn_first < 0) dn_first = cyc;
      else if (dn_second < 0) dn_second = cyc;
      dn_last = cyc;
    end
    if (dbg_db[0]) db_up_rose = 1'b1;
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  k0;
  logic seen;

  initial begin
    clear_mon();
    step(3);
    check("reset_moveUp", move_up, 0);
    check("reset_moveDown", move_dn, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    step(3);

    // Clean press held 40 cycles: first pulse 7 edges after first sample, then every 8
    clear_mon();
    btn_up = 1'b1;
    k0 = cyc + 1;
    step(40);
    btn_up = 1'b0;
    step(12);
    check("press_first_offset", up_first - k0, 7);
    check("press_period", up_second - up_first, 8);
    check("press_up_count", up_count, 5);
    check("press_dn_count", dn_count, 0);

    // Bounce: 1,1,0,0,... for 20 cycles never holds for D samples
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2) == 0;
      step(1);
    end
    btn_up = 1'b0;
    step(10);
    check("bounce_up_count", up_count, 0);
    check("bounce_db_rose", db_up_rose, 0);

    // Both held: no motion; releasing Down lets Up through D+3 edges later
    clear_mon();
    btn_up = 1'b1;
    btn_dn = 1'b1;
    step(30);
    check("both_pulses", up_count + dn_count, 0);
    clear_mon();
    btn_dn = 1'b0;
    k0 = cyc + 1;
    step(12);
    check("both_release_offset", up_first - k0, D + 3);
    btn_up = 1'b0;
    step(12);

    // Up to Down switch with no gap
    clear_mon();
    btn_up = 1'b1;
    step(20);
    btn_up = 1'b0;
    btn_dn = 1'b1;
    k0 = cyc + 1;
    step(20);
    btn_dn = 1'b0;
    step(12);
    check("switch_last_up", up_last - k0, 3);
    check("switch_first_dn", dn_first - k0, 8);

    // Paused game: Down held with Enable low, then Enable rises
    clear_mon();
    enable = 1'b0;
    btn_dn = 1'b1;
    step(20);
    check("paused_pulses", dn_count + up_count, 0);
    enable = 1'b1;
    k0 = cyc + 1;
    step(20);
    check("enable_first_dn", dn_first - k0, 1);
    check("enable_period", dn_second - dn_first, 8);
    btn_dn = 1'b0;
    step(12);

    // Asynchronous reset in the middle of a pulse, then full re-qualification
    btn_up = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = move_up;
    end
    check("reset_wait_pulse", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_moveUp", move_up, 0);
    check("async_moveDown", move_dn, 0);
    check("async_state", dbg_state, 0);
    check("async_db", dbg_db, 0);
    @(posedge clk);
    #2;
    clear_mon();
    rst_n = 1'b1;
    k0 = cyc + 1;
    step(15);
    check("rereset_first_offset", up_first - k0, 7);
    btn_up = 1'b0;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
